// File: rtl/writeback_stage.sv
// Writeback stage: registers the memory-stage result onto the register-file write port and
// holds the pipeline while a load response is outstanding. Optional: WRITEBACK_INSTRET_EN.
module writeback_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned PC_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
`ifdef WRITEBACK_INSTRET_EN
  output logic [63:0]       instret_o,
`endif
  input  logic              stall_v_i,
  input  logic              flush_v_i,
  input  logic              mem_v_i,
  input  logic [PC_W-1:0]   mem_pc_i,
  input  logic              mem_rd_w_v_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic [XLEN-1:0]   mem_result_i,
  input  logic              mem_load_v_i,
  input  logic [2:0]        mem_funct3_i,
  input  logic [1:0]        mem_addr_lo_i,
  input  logic              dmem_rsp_v_i,
  input  logic [XLEN-1:0]   dmem_rsp_data_i,
  output logic              writeback_rd_w_v_o,
  output logic [REG_AW-1:0] writeback_rd_o,
  output logic [XLEN-1:0]   writeback_rd_data_o,
  output logic              stall_v_o,
  output logic              retire_v_o,
  output logic [PC_W-1:0]   retire_pc_o
);

  typedef enum logic [0:0] {StIdle, StLoadWait} state_e;

  state_e state_q, state_d;

  logic              wb_v_q, wb_v_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              ret_v_q, ret_v_d;
  logic [PC_W-1:0]   ret_pc_q, ret_pc_d;

  // Load held while waiting for the data-memory response.
  logic              hold_rd_w_v_q, hold_rd_w_v_d;
  logic [REG_AW-1:0] hold_rd_q, hold_rd_d;
  logic [2:0]        hold_funct3_q, hold_funct3_d;
  logic [1:0]        hold_addr_lo_q, hold_addr_lo_d;
  logic [PC_W-1:0]   hold_pc_q, hold_pc_d;

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  always_comb begin
    ld_byte = dmem_rsp_data_i[7:0];
    unique case (hold_addr_lo_q)
      2'd0: ld_byte = dmem_rsp_data_i[7:0];
      2'd1: ld_byte = dmem_rsp_data_i[15:8];
      2'd2: ld_byte = dmem_rsp_data_i[23:16];
      2'd3: ld_byte = dmem_rsp_data_i[31:24];
      default: ld_byte = dmem_rsp_data_i[7:0];
    endcase
    ld_half = hold_addr_lo_q[1] ? dmem_rsp_data_i[31:16] : dmem_rsp_data_i[15:0];
    case (hold_funct3_q)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = dmem_rsp_data_i;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    wb_v_d         = 1'b0;
    ret_v_d        = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    ret_pc_d       = ret_pc_q;
    hold_rd_w_v_d  = hold_rd_w_v_q;
    hold_rd_d      = hold_rd_q;
    hold_funct3_d  = hold_funct3_q;
    hold_addr_lo_d = hold_addr_lo_q;
    hold_pc_d      = hold_pc_q;
    case (state_q)
      StIdle: begin
        if (mem_v_i && !stall_v_i && !flush_v_i) begin
          if (mem_load_v_i) begin
            hold_rd_w_v_d  = mem_rd_w_v_i;
            hold_rd_d      = mem_rd_i;
            hold_funct3_d  = mem_funct3_i;
            hold_addr_lo_d = mem_addr_lo_i;
            hold_pc_d      = mem_pc_i;
            state_d        = StLoadWait;
          end else begin
            wb_v_d    = mem_rd_w_v_i && (mem_rd_i != '0);
            wb_rd_d   = mem_rd_i;
            wb_data_d = mem_result_i;
            ret_v_d   = 1'b1;
            ret_pc_d  = mem_pc_i;
          end
        end
      end
      StLoadWait: begin
        // Upstream inputs are ignored here; the load is already committed.
        if (dmem_rsp_v_i) begin
          wb_v_d    = hold_rd_w_v_q && (hold_rd_q != '0);
          wb_rd_d   = hold_rd_q;
          wb_data_d = ld_data;
          ret_v_d   = 1'b1;
          ret_pc_d  = hold_pc_q;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      wb_v_q         <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      ret_v_q        <= 1'b0;
      ret_pc_q       <= '0;
      hold_rd_w_v_q  <= 1'b0;
      hold_rd_q      <= '0;
      hold_funct3_q  <= '0;
      hold_addr_lo_q <= '0;
      hold_pc_q      <= '0;
    end else begin
      state_q        <= state_d;
      wb_v_q         <= wb_v_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      ret_v_q        <= ret_v_d;
      ret_pc_q       <= ret_pc_d;
      hold_rd_w_v_q  <= hold_rd_w_v_d;
      hold_rd_q      <= hold_rd_d;
      hold_funct3_q  <= hold_funct3_d;
      hold_addr_lo_q <= hold_addr_lo_d;
      hold_pc_q      <= hold_pc_d;
    end
  end

`ifdef WRITEBACK_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instret_q <= '0;
    end else if (ret_v_q) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret_o = instret_q;
`endif

  assign stall_v_o           = (state_q == StLoadWait);
  assign writeback_rd_w_v_o  = wb_v_q;
  assign writeback_rd_o      = wb_rd_q;
  assign writeback_rd_data_o = wb_data_q;
  assign retire_v_o          = ret_v_q;
  assign retire_pc_o         = ret_pc_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed table-driven bench for writeback_stage, plus hand sequences for load timing and reset.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_in, flush_in, mem_v, rd_w_v, load_v, rsp_v;
  logic [31:0] pc, result, rsp_data;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic        wb_v, stall_out, ret_v;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, ret_pc;
`ifdef WRITEBACK_INSTRET_EN
  logic [63:0] instret;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
`ifdef WRITEBACK_INSTRET_EN
    .instret_o           (instret),
`endif
    .stall_v_i           (stall_in),
    .flush_v_i           (flush_in),
    .mem_v_i             (mem_v),
    .mem_pc_i            (pc),
    .mem_rd_w_v_i        (rd_w_v),
    .mem_rd_i            (rd),
    .mem_result_i        (result),
    .mem_load_v_i        (load_v),
    .mem_funct3_i        (funct3),
    .mem_addr_lo_i       (addr_lo),
    .dmem_rsp_v_i        (rsp_v),
    .dmem_rsp_data_i     (rsp_data),
    .writeback_rd_w_v_o  (wb_v),
    .writeback_rd_o      (wb_rd),
    .writeback_rd_data_o (wb_data),
    .stall_v_o           (stall_out),
    .retire_v_o          (ret_v),
    .retire_pc_o         (ret_pc)
  );

  typedef struct {
    logic        mem_v, stall, flush, rd_w_v;
    logic [4:0]  rd;
    logic [31:0] pc, result;
    logic        load;
    logic [2:0]  f3;
    logic [1:0]  al;
    logic [31:0] rsp;
    int          delay;
    logic        exp_wv;
    logic [31:0] exp_data;
    logic        exp_ret;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_v = 0; stall_in = 0; flush_in = 0; rd_w_v = 0; load_v = 0; rsp_v = 0;
    rd = 0; pc = 0; result = 0; funct3 = 0; addr_lo = 0; rsp_data = 0;
  endtask

  task automatic drive_mem(input logic ld, input logic [4:0] r, input logic [31:0] p,
                           input logic [31:0] res, input logic [2:0] f, input logic [1:0] a);
    mem_v = 1; rd_w_v = 1; load_v = ld; rd = r; pc = p; result = res; funct3 = f; addr_lo = a;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    mem_v = v.mem_v; stall_in = v.stall; flush_in = v.flush; rd_w_v = v.rd_w_v; rd = v.rd;
    pc = v.pc; result = v.result; load_v = v.load; funct3 = v.f3; addr_lo = v.al;
    @(negedge clk);
    mem_v = 0; stall_in = 0; flush_in = 0;
    if (v.load) begin
      for (int i = 0; i < v.delay; i++) begin
        chk($sformatf("v%0d stall wait", idx), stall_out, 1);
        chk($sformatf("v%0d no early write", idx), wb_v, 0);
        @(negedge clk);
      end
      chk($sformatf("v%0d stall rsp cycle", idx), stall_out, 1);
      rsp_v = 1; rsp_data = v.rsp;
      @(negedge clk);
      rsp_v = 0;
    end
    chk($sformatf("v%0d wr_v", idx), wb_v, v.exp_wv);
    chk($sformatf("v%0d retire", idx), ret_v, v.exp_ret);
    chk($sformatf("v%0d stall low", idx), stall_out, 0);
    if (v.exp_wv) begin
      chk($sformatf("v%0d rd", idx), wb_rd, v.rd);
      chk($sformatf("v%0d data", idx), wb_data, v.exp_data);
    end
    if (v.exp_ret) chk($sformatf("v%0d pc", idx), ret_pc, v.pc);
  endtask

  initial begin
    //          mv st fl wv rd  pc          result        ld f3    al rsp           dly ewv edata         eret
    vecs[0]  = '{1, 0, 0, 1, 5, 32'h100, 32'h1234_5678, 0, 3'd0, 0, 32'h0,         0, 1, 32'h1234_5678, 1};
    vecs[1]  = '{1, 0, 0, 1, 7, 32'h104, 32'h0,         1, 3'd0, 2, 32'h0080_0000, 3, 1, 32'hFFFF_FF80, 1};
    vecs[2]  = '{1, 0, 0, 1, 9, 32'h108, 32'h0,         1, 3'd5, 2, 32'hBEEF_0000, 1, 1, 32'h0000_BEEF, 1};
    vecs[3]  = '{1, 0, 0, 1, 0, 32'h10C, 32'hDEAD_BEEF, 0, 3'd0, 0, 32'h0,         0, 0, 32'h0,         1};
    vecs[4]  = '{1, 0, 1, 1, 8, 32'h110, 32'h5555_5555, 0, 3'd0, 0, 32'h0,         0, 0, 32'h0,         0};
    vecs[5]  = '{1, 1, 0, 1, 8, 32'h114, 32'h6666_6666, 0, 3'd0, 0, 32'h0,         0, 0, 32'h0,         0};
    vecs[6]  = '{1, 0, 0, 1, 3, 32'h118, 32'h0,         1, 3'd1, 0, 32'h1234_8001, 2, 1, 32'hFFFF_8001, 1};
    vecs[7]  = '{1, 0, 0, 1, 4, 32'h11C, 32'h0,         1, 3'd2, 1, 32'hCAFE_BABE, 0, 1, 32'hCAFE_BABE, 1};
    vecs[8]  = '{1, 0, 0, 1, 10, 32'h120, 32'h0,        1, 3'd4, 3, 32'h9A00_0000, 1, 1, 32'h0000_009A, 1};
    vecs[9]  = '{1, 0, 0, 1, 11, 32'h124, 32'h0,        1, 3'd0, 0, 32'h0000_007F, 0, 1, 32'h0000_007F, 1};
    vecs[10] = '{1, 0, 0, 1, 12, 32'h128, 32'h0,        1, 3'd3, 1, 32'h1122_3344, 0, 1, 32'h1122_3344, 1};
    vecs[11] = '{1, 0, 0, 0, 6, 32'h12C, 32'h7777_7777, 0, 3'd0, 0, 32'h0,         0, 0, 32'h0,         1};
    vecs[12] = '{1, 0, 0, 1, 13, 32'h130, 32'h0,        1, 3'd5, 0, 32'h0000_8001, 0, 1, 32'h0000_8001, 1};

    idle_inputs();
    rst_n = 0;
    #12;
    chk("reset wr_v", wb_v, 0);
    chk("reset retire", ret_v, 0);
    chk("reset stall", stall_out, 0);
    chk("reset data", wb_data, 0);
    chk("reset pc", ret_pc, 0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Stray response while idle.
    @(negedge clk);
    rsp_v = 1; rsp_data = 32'hFFFF_FFFF;
    @(negedge clk);
    rsp_v = 0;
    chk("stray rsp wr_v", wb_v, 0);
    chk("stray rsp retire", ret_v, 0);

    // New instruction offered mid-wait is ignored; one captured in the write cycle is accepted.
    @(negedge clk);
    drive_mem(1, 14, 32'h200, 32'h0, 3'd2, 0);
    @(negedge clk);
    drive_mem(0, 20, 32'h204, 32'h1, 3'd0, 0);
    chk("b2b stall", stall_out, 1);
    @(negedge clk);
    mem_v = 0; rsp_v = 1; rsp_data = 32'hAABB_CCDD;
    @(negedge clk);
    rsp_v = 0;
    chk("b2b load wr_v", wb_v, 1);
    chk("b2b load rd", wb_rd, 14);
    chk("b2b load data", wb_data, 32'hAABB_CCDD);
    chk("b2b stall drop", stall_out, 0);
    drive_mem(0, 21, 32'h208, 32'h55, 3'd0, 0);
    @(negedge clk);
    mem_v = 0;
    chk("b2b alu wr_v", wb_v, 1);
    chk("b2b alu rd", wb_rd, 21);
    chk("b2b alu data", wb_data, 32'h55);
    chk("b2b alu pc", ret_pc, 32'h208);
    @(negedge clk);
    chk("ignored instr retire", ret_v, 0);

    // Reset during load wait drops the load.
    drive_mem(1, 15, 32'h300, 32'h0, 3'd2, 0);
    @(negedge clk);
    mem_v = 0;
    chk("pre-reset stall", stall_out, 1);
    rst_n = 0;
    #1;
    chk("async reset stall", stall_out, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    rsp_v = 1; rsp_data = 32'h1111_1111;
    @(negedge clk);
    rsp_v = 0;
    chk("post-reset rsp wr_v", wb_v, 0);
    chk("post-reset rsp retire", ret_v, 0);

`ifdef WRITEBACK_INSTRET_EN
    chk("instret after reset", instret, 0);
    for (int i = 0; i < 3; i++) run_vec(vecs[0], 100 + i);
    @(negedge clk);
    chk("instret count", instret, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
